// File: rtl/shift_storage_pkg.sv
// Shared definitions for the shift storage bank.
//   mode_e     : operation select encoding on the bank's mode input
//   fill_width : bits needed to count 0..depth valid words
package shift_storage_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_e;

  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/storage_word.sv
// One Width-bit storage stage of the shift storage bank.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low clear
//   en_i    : update enable; state holds when low
//   set_i   : synchronous set-all-ones (wins only when clr_i is low)
//   clr_i   : synchronous clear (wins only when set_i is low)
//   d_i     : next value taken when enabled and neither set_i nor clr_i is high
//   q_o     : registered stage value
module storage_word #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      if (set_i && !clr_i) begin
        q_d = '1;
      end else if (clr_i && !set_i) begin
        q_d = '0;
      end else if (!set_i && !clr_i) begin
        q_d = d_i;
      end
      // set and clr together: hold
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_storage_bank.sv
// Bank of DEPTH storage words with shift, parallel load, optional rotate,
// synchronous set/clear and a saturating fill counter.
// Optional feature: define SHIFT_STORAGE_ROTATE_EN to make mode 11 rotate;
// otherwise mode 11 holds and no rotate feedback exists.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   en        : operation enable; all state holds when low
//   set, clr  : synchronous set-all / clear-all (both high = hold)
//   mode      : 00 hold, 01 shift, 10 load, 11 rotate
//   d_in      : word shifted into stage 0
//   load_data : parallel image, word k at [k*WIDTH +: WIDTH]
//   q_out     : stage DEPTH-1 (oldest word)
//   q_all     : all stages, same layout as load_data
//   fill      : number of valid words (0..DEPTH)
//   full      : high when fill == DEPTH
module shift_storage_bank
  import shift_storage_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           set,
  input  logic                           clr,
  input  logic [1:0]                     mode,
  input  logic [WIDTH-1:0]               d_in,
  input  logic [WIDTH*DEPTH-1:0]         load_data,
  output logic [WIDTH-1:0]               q_out,
  output logic [WIDTH*DEPTH-1:0]         q_all,
  output logic [fill_width(DEPTH)-1:0]   fill,
  output logic                           full
);

  localparam int unsigned FillW = fill_width(DEPTH);
  localparam logic [FillW-1:0] FillMax = FillW'(DEPTH);

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Per-stage next value for the mode path; set/clr/en are applied in each word.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    unique case (mode_sel)
      MODE_SHIFT: begin
        stage_d[0] = d_in;
        for (int k = 1; k < DEPTH; k++) begin
          stage_d[k] = stage_q[k-1];
        end
      end
      MODE_LOAD: begin
        for (int k = 0; k < DEPTH; k++) begin
          stage_d[k] = load_data[k*WIDTH +: WIDTH];
        end
      end
      MODE_ROTATE: begin
`ifdef SHIFT_STORAGE_ROTATE_EN
        stage_d[0] = stage_q[DEPTH-1];
        for (int k = 1; k < DEPTH; k++) begin
          stage_d[k] = stage_q[k-1];
        end
`endif
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    storage_word #(
      .Width (WIDTH)
    ) u_word (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (en),
      .set_i  (set),
      .clr_i  (clr),
      .d_i    (stage_d[k]),
      .q_o    (stage_q[k])
    );
    assign q_all[k*WIDTH +: WIDTH] = stage_q[k];
  end

  assign q_out = stage_q[DEPTH-1];

  logic [FillW-1:0] fill_d, fill_q;
  logic             full_q;

  always_comb begin
    fill_d = fill_q;
    if (en) begin
      if (set && !clr) begin
        fill_d = FillMax;
      end else if (clr && !set) begin
        fill_d = '0;
      end else if (!set && !clr) begin
        unique case (mode_sel)
          MODE_SHIFT: if (fill_q != FillMax) fill_d = fill_q + 1'b1;
          MODE_LOAD:  fill_d = FillMax;
          default:    ;
        endcase
      end
    end
  end

  // full is registered from fill_d so it tracks fill on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= (fill_d == FillMax);
    end
  end

  assign fill = fill_q;
  assign full = full_q;

endmodule

// File: tb/tb_shift_storage_bank.sv
module tb_shift_storage_bank;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        set;
  logic        clr;
  logic [1:0]  mode;
  logic [3:0]  d_in;
  logic [31:0] load_data;
  logic [3:0]  q_out;
  logic [31:0] q_all;
  logic [3:0]  fill;
  logic        full;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_storage_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .set       (set),
    .clr       (clr),
    .mode      (mode),
    .d_in      (d_in),
    .load_data (load_data),
    .q_out     (q_out),
    .q_all     (q_all),
    .fill      (fill),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_all, input logic [3:0] e_fill,
                             input logic e_full);
    check({tag, ".q_all"}, q_all, e_all);
    check({tag, ".q_out"}, {28'd0, q_out}, {28'd0, e_all[31:28]});
    check({tag, ".fill"}, {28'd0, fill}, {28'd0, e_fill});
    check({tag, ".full"}, {31'd0, full}, {31'd0, e_full});
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; set = 1'b0; clr = 1'b0;
    mode = 2'b00; d_in = '0; load_data = '0;
    #12;
    check_state("reset", 32'h0, 4'd0, 1'b0);
    reset = 1'b1;
    tick();

    // Shift 1..8
    en = 1'b1; mode = 2'b01;
    d_in = 4'd1;
    tick();
    check_state("shift1", 32'h0000_0001, 4'd1, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      d_in = 4'(i);
      tick();
    end
    check_state("shift8", 32'h1234_5678, 4'd8, 1'b1);
    d_in = 4'd9;
    tick();
    check_state("shift9_sat", 32'h2345_6789, 4'd8, 1'b1);

    // Load word k = k+3
    mode = 2'b10; load_data = 32'hA987_6543;
    tick();
    check_state("load", 32'hA987_6543, 4'd8, 1'b1);

    // Mode 11: rotate when enabled, hold otherwise
    mode = 2'b11;
    tick();
`ifdef SHIFT_STORAGE_ROTATE_EN
    check_state("rot1", 32'h9876_543A, 4'd8, 1'b1);
`else
    check_state("m11_hold1", 32'hA987_6543, 4'd8, 1'b1);
`endif
    for (int i = 2; i <= 8; i++) begin
      tick();
      check({"m11_fill"}, {28'd0, fill}, 32'd8);
    end
    check_state("m11_final", 32'hA987_6543, 4'd8, 1'b1);

    // set+clr together hold, mode ignored
    mode = 2'b10; load_data = 32'hAAAA_AAAA;
    tick();
    set = 1'b1; clr = 1'b1; mode = 2'b01; d_in = 4'h3;
    tick();
    check_state("setclr", 32'hAAAA_AAAA, 4'd8, 1'b1);
    set = 1'b0;
    tick();
    check_state("clr", 32'h0, 4'd0, 1'b0);
    clr = 1'b0; set = 1'b1;
    tick();
    check_state("set", 32'hFFFF_FFFF, 4'd8, 1'b1);
    set = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; mode = 2'b01; d_in = 4'h5;
    tick();
    check_state("shift5", 32'h0000_0005, 4'd1, 1'b0);

    // en low freezes everything
    en = 1'b0; set = 1'b1; mode = 2'b01; d_in = 4'hF;
    repeat (5) tick();
    check_state("en_low", 32'h0000_0005, 4'd1, 1'b0);

    // Three shifts then async reset between edges
    en = 1'b1; set = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      d_in = 4'(i);
      tick();
    end
    check_state("pre_rst", 32'h0000_5123, 4'd4, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_rst", 32'h0, 4'd0, 1'b0);
    #1;
    reset = 1'b1;
    d_in = 4'h7;
    tick();
    check_state("post_rst", 32'h0000_0007, 4'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_storage_bank.md
SHIFT_STORAGE_BANK -- requirements
Module: shift_storage_bank

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bits per storage word (legal range 1..32).
REQ-002 Parameter DEPTH, default 8, SHALL set the number of words in the bank (legal range 2..64).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the operation enable; when low, all state SHALL hold.
REQ-006 set  input  1  SHALL be the synchronous set-all request.
REQ-007 clr  input  1  SHALL be the synchronous clear-all request.
REQ-008 mode  input  2  SHALL select the operation: 00 hold, 01 shift, 10 parallel load, 11 rotate.
REQ-009 d_in  input  WIDTH  SHALL be the serial word shifted into stage 0.
REQ-010 load_data  input  WIDTH*DEPTH  SHALL be the parallel load image; word k SHALL occupy bits [k*WIDTH +: WIDTH].
REQ-011 q_out  output  WIDTH  SHALL be stage DEPTH-1 (the oldest word).
REQ-012 q_all  output  WIDTH*DEPTH  SHALL be all stages, packed with the same layout as load_data.
REQ-013 fill  output  clog2(DEPTH+1)  SHALL be the count of valid words.
REQ-014 full  output  1  SHALL be high exactly when fill equals DEPTH.

Function
REQ-015 All outputs SHALL be registered; a change caused by edge n SHALL be visible after edge n, with no combinational path from inputs to outputs.
REQ-016 Priority at each edge SHALL be: en low, then set/clr, then mode.
REQ-017 set=1 with clr=0 SHALL load all ones into every stage and set fill to DEPTH.
REQ-018 clr=1 with set=0 SHALL load zeros into every stage and set fill to 0.
REQ-019 set=1 with clr=1 SHALL be treated as a no-change state: stages and fill hold, and mode SHALL be ignored.
REQ-020 In shift mode, stage 0 SHALL take d_in and stage k SHALL take stage k-1 for k = 1..DEPTH-1; the old stage DEPTH-1 SHALL be discarded.
REQ-021 In shift mode, fill SHALL increment by 1, saturating at DEPTH; a shift while full SHALL keep fill at DEPTH.
REQ-022 In load mode, every stage SHALL take its load_data word and fill SHALL become DEPTH.
REQ-023 In rotate mode, stage 0 SHALL take stage DEPTH-1, the remaining stages SHALL shift as in shift mode, and fill SHALL be unchanged.
REQ-024 In hold mode, stages and fill SHALL be unchanged.
REQ-025 fill arithmetic SHALL never wrap; it SHALL stay within 0..DEPTH at all times.

Reset
REQ-026 reset low SHALL immediately, without a clock edge, force all stages to 0, fill to 0, full to 0, q_out to 0 and q_all to 0.
REQ-027 While reset is low, the block SHALL ignore en, set, clr and mode.
REQ-028 reset asserted mid-operation SHALL abandon any pending update; the first edge after release SHALL operate on the all-zero state.

Configuration
REQ-029 With SHIFT_STORAGE_ROTATE_EN defined, mode 11 SHALL perform rotate as specified in REQ-023.
REQ-030 Without SHIFT_STORAGE_ROTATE_EN, mode 11 SHALL behave as hold, and no rotate feedback path SHALL be synthesised.

Structure
REQ-031 Package shift_storage_pkg SHALL hold the mode encoding (an enum: MODE_HOLD, MODE_SHIFT, MODE_LOAD, MODE_ROTATE) and the fill-width function.
REQ-032 One sub-module, storage_word, SHALL implement a single WIDTH-bit stage (async active-low clear, sync set/clr, next-value input); the bank SHALL instantiate DEPTH of them in a generate loop.

Verification (WIDTH=4, DEPTH=8)
REQ-033 Reset then release, shift d_in 1,2,...,8 over 8 edges -> q_out=1, full=1 after the 8th edge; a 9th shift of 9 -> q_out=2, fill stays 8.
REQ-034 Load with word k=k+3, then rotate 8 edges -> q_all equals the original image, and fill=8 throughout.
REQ-035 Assert set and clr together after load of 0xA in every word -> every word stays 0xA; then clr alone -> all zero, fill=0, full=0.
REQ-036 en=0 with mode=01 and set=1 for 5 edges -> no change to q_all or fill.
REQ-037 Assert reset low between edges after 3 shifts -> outputs read 0 before the next edge; the next shift after release gives fill=1.
REQ-038 Build without SHIFT_STORAGE_ROTATE_EN; mode 11 for 4 edges -> q_all unchanged.
